// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter block.
// Holds the operation codes and the helper that sizes the stack-occupancy bus.
package pc_pkg;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_CALL  = 3'b100;
  localparam logic [2:0] OP_RET   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // Bits needed to represent an occupancy of 0..depth.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for pc_stack.
// Ports:
//   clk, rst_n   - clock, async active-low reset (clears occupancy only)
//   clear        - synchronous empty, overrides push/pop
//   push, pop    - push push_data / discard top entry; ignored when full / empty
//   push_data    - address to push
//   top_data_c   - combinational top-of-stack entry (meaningful only when not empty)
//   level        - registered occupancy
//   full_c       - level == DEPTH
//   empty_c      - level == 0
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            push_data,
  output logic [WIDTH-1:0]            top_data_c,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full_c,
  output logic                        empty_c
);

  localparam int unsigned LW = level_w(DEPTH);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_push;
  logic             do_pop;

  assign full_c     = (level_q == LW'(DEPTH));
  assign empty_c    = (level_q == '0);
  assign level      = level_q;
  // Entries at or above level are stale; only the one just below is exposed.
  assign top_data_c = mem_q[IW'(level_q - LW'(1))];

  // Next occupancy; clear wins over push/pop.
  always_comb begin
    do_push = push && !full_c && !clear;
    do_pop  = pop && !empty_c && !clear;
    level_d = level_q;
    if (clear) begin
      level_d = '0;
    end else if (do_push) begin
      level_d = level_q + LW'(1);
    end else if (do_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Storage has no reset; unused slots are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[IW'(level_q)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with increment/load/relative-add and a call/return stack.
// Ports:
//   CLK, RESET_n - clock, async active-low reset
//   A            - load/call address or signed offset for ADD
//   OP           - operation code (see pc_pkg)
//   OE_n         - active-low enable of the Q tri-state driver
//   Q            - PC value, or high-Z when OE_n=1
//   WRAP         - one cycle pulse after an INC/ADD that wrapped
//   FULL, EMPTY  - stack occupancy decodes
//   LEVEL        - stack occupancy
//   ERR          - sticky overflow/underflow flag, cleared by reset or CLEAR
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       DEPTH       = 4,
  parameter int unsigned       STEP        = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                       CLK,
  input  logic                       RESET_n,
  input  logic [WIDTH-1:0]           A,
  input  logic [2:0]                 OP,
  input  logic                       OE_n,
  output tri   [WIDTH-1:0]           Q,
  output logic                       WRAP,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [level_w(DEPTH)-1:0]  LEVEL,
  output logic                       ERR
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             push, pop, clear;
  logic [WIDTH-1:0] top_data;
  logic             full, empty;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   add_sum;

  // Extra top bit carries out of the PC width.
  assign inc_sum = {1'b0, pc_q} + {1'b0, STEP_W};
  assign add_sum = {1'b0, pc_q} + {1'b0, A};

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk        (CLK),
    .rst_n      (RESET_n),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .push_data  (inc_sum[WIDTH-1:0]),
    .top_data_c (top_data),
    .level      (LEVEL),
    .full_c     (full),
    .empty_c    (empty)
  );

  // Operation decode.
  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    push   = 1'b0;
    pop    = 1'b0;
    clear  = 1'b0;
    case (OP)
      OP_INC: begin
        pc_d   = inc_sum[WIDTH-1:0];
        wrap_d = inc_sum[WIDTH];
      end
      OP_LOAD: begin
        pc_d = A;
      end
      OP_ADD: begin
        pc_d   = add_sum[WIDTH-1:0];
        // Negative offset wraps when no carry comes out (a borrow through 0).
        wrap_d = A[WIDTH-1] ? ~add_sum[WIDTH] : add_sum[WIDTH];
      end
      OP_CALL: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = A;
        end
      end
      OP_RET: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = top_data;
        end
      end
      OP_CLEAR: begin
        pc_d  = RESET_VALUE;
        err_d = 1'b0;
        clear = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // PC and status registers.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      pc_q   <= RESET_VALUE;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Q     = OE_n ? {WIDTH{1'bz}} : pc_q;
  assign WRAP  = wrap_q;
  assign ERR   = err_q;
  assign FULL  = full;
  assign EMPTY = empty;

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (default parameters).
module tb_pc_stack;
  import pc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [2:0]  op;
  logic        oe_n;
  // Pulled up so an undriven bus reads as all ones.
  tri1  [31:0] q;
  logic        wrap;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        err;

  int checks = 0;
  int errors = 0;

  pc_stack dut (
    .CLK     (clk),
    .RESET_n (rst_n),
    .A       (a),
    .OP      (op),
    .OE_n    (oe_n),
    .Q       (q),
    .WRAP    (wrap),
    .FULL    (full),
    .EMPTY   (empty),
    .LEVEL   (level),
    .ERR     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply an op on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [2:0] o, input logic [31:0] addr);
    @(negedge clk);
    op = o;
    a  = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stack(input string tag, input logic [2:0] lv, input logic f,
                           input logic e, input logic er);
    chk({tag, "_level"}, 64'(level), 64'(lv));
    chk({tag, "_full"},  64'(full),  64'(f));
    chk({tag, "_empty"}, 64'(empty), 64'(e));
    chk({tag, "_err"},   64'(err),   64'(er));
  endtask

  initial begin
    rst_n = 1'b0;
    oe_n  = 1'b0;
    op    = OP_HOLD;
    a     = '0;
    #3;
    chk("rst_q", 64'(q), 64'h0);
    chk("rst_wrap", 64'(wrap), 64'h0);
    chk_stack("rst", 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // INC x3 from reset
    step(OP_INC, 32'h0);
    chk("inc1_q", 64'(q), 64'h1);
    step(OP_INC, 32'h0);
    chk("inc2_q", 64'(q), 64'h2);
    step(OP_INC, 32'h0);
    chk("inc3_q", 64'(q), 64'h3);
    chk("inc3_wrap", 64'(wrap), 64'h0);
    chk("inc3_empty", 64'(empty), 64'h1);

    // Wrap through 2^32 on INC, WRAP for one cycle only
    step(OP_LOAD, 32'hFFFF_FFFE);
    chk("ld_q", 64'(q), 64'hFFFF_FFFE);
    step(OP_INC, 32'h0);
    chk("incw1_q", 64'(q), 64'hFFFF_FFFF);
    chk("incw1_wrap", 64'(wrap), 64'h0);
    step(OP_INC, 32'h0);
    chk("incw2_q", 64'(q), 64'h0);
    chk("incw2_wrap", 64'(wrap), 64'h1);
    step(OP_HOLD, 32'h0);
    chk("hold_q", 64'(q), 64'h0);
    chk("hold_wrap", 64'(wrap), 64'h0);

    // Signed relative adds
    step(OP_LOAD, 32'h100);
    step(OP_ADD, 32'hFFFF_FFF0);
    chk("addn_q", 64'(q), 64'hF0);
    chk("addn_wrap", 64'(wrap), 64'h0);
    step(OP_ADD, 32'h20);
    chk("addp_q", 64'(q), 64'h110);
    chk("addp_wrap", 64'(wrap), 64'h0);
    step(OP_LOAD, 32'h5);
    step(OP_ADD, 32'hFFFF_FFFC);
    chk("addu_q", 64'(q), 64'h1);
    chk("addu_wrap", 64'(wrap), 64'h0);
    step(OP_ADD, 32'hFFFF_FFFE);
    chk("addb_q", 64'(q), 64'hFFFF_FFFF);
    chk("addb_wrap", 64'(wrap), 64'h1);
    step(OP_ADD, 32'h2);
    chk("addc_q", 64'(q), 64'h1);
    chk("addc_wrap", 64'(wrap), 64'h1);

    // Fill the stack, overflow, drain
    step(OP_LOAD, 32'h10);
    step(OP_CALL, 32'h200);
    chk("call1_q", 64'(q), 64'h200);
    chk_stack("call1", 3'd1, 1'b0, 1'b0, 1'b0);
    step(OP_CALL, 32'h200);
    chk_stack("call2", 3'd2, 1'b0, 1'b0, 1'b0);
    step(OP_CALL, 32'h200);
    chk_stack("call3", 3'd3, 1'b0, 1'b0, 1'b0);
    step(OP_CALL, 32'h200);
    chk("call4_q", 64'(q), 64'h200);
    chk_stack("call4", 3'd4, 1'b1, 1'b0, 1'b0);
    step(OP_CALL, 32'h300);
    chk("call5_q", 64'(q), 64'h200);
    chk_stack("call5", 3'd4, 1'b1, 1'b0, 1'b1);
    step(OP_RET, 32'h0);
    chk("ret1_q", 64'(q), 64'h201);
    chk_stack("ret1", 3'd3, 1'b0, 1'b0, 1'b1);
    step(OP_RET, 32'h0);
    chk("ret2_q", 64'(q), 64'h201);
    step(OP_RET, 32'h0);
    chk("ret3_q", 64'(q), 64'h201);
    step(OP_RET, 32'h0);
    chk("ret4_q", 64'(q), 64'h11);
    chk_stack("ret4", 3'd0, 1'b0, 1'b1, 1'b1);

    // Underflow, then CLEAR
    step(OP_CLEAR, 32'h0);
    chk_stack("clr1", 3'd0, 1'b0, 1'b1, 1'b0);
    step(OP_LOAD, 32'h44);
    step(OP_RET, 32'h0);
    chk("retu_q", 64'(q), 64'h44);
    chk_stack("retu", 3'd0, 1'b0, 1'b1, 1'b1);
    step(OP_CALL, 32'h80);
    chk("callc_q", 64'(q), 64'h80);
    step(OP_CLEAR, 32'h0);
    chk("clr2_q", 64'(q), 64'h0);
    chk_stack("clr2", 3'd0, 1'b0, 1'b1, 1'b0);

    // Output enable: counting continues while the bus is released
    @(negedge clk);
    oe_n = 1'b1;
    op   = OP_HOLD;
    #1;
    chk("oe_off_q", 64'(q), 64'hFFFF_FFFF);
    step(OP_INC, 32'h0);
    step(OP_INC, 32'h0);
    chk("oe_inc_q", 64'(q), 64'hFFFF_FFFF);
    @(negedge clk);
    oe_n = 1'b0;
    op   = OP_HOLD;
    #1;
    chk("oe_on_q", 64'(q), 64'h2);

    // Async reset between edges abandons the pending INC/CALL state
    step(OP_CALL, 32'h40);
    chk("prer_q", 64'(q), 64'h40);
    @(negedge clk);
    op = OP_INC;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_q", 64'(q), 64'h0);
    chk("arst_wrap", 64'(wrap), 64'h0);
    chk_stack("arst", 3'd0, 1'b0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_q", 64'(q), 64'h1);
    chk("post_rst_level", 64'(level), 64'h0);

    // Reserved opcode behaves as HOLD
    step(OP_RSVD, 32'h123);
    chk("rsvd_q", 64'(q), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 32, counter/address width in bits (SHALL be >= 4).
REQ-002 Parameter DEPTH, default 4, return-stack entries (SHALL be >= 1).
REQ-003 Parameter STEP, default 1, increment added by INC and used as the CALL return offset.
REQ-004 Parameter RESET_VALUE, default 0, PC value after reset and after CLEAR.
REQ-005 CLK  in  1  single clock; all state SHALL change on its rising edge only.
REQ-006 RESET_n  in  1  reset; asynchronous, active-low.
REQ-007 A  in  WIDTH  load address, or two's-complement offset for ADD.
REQ-008 OP  in  3  operation code, sampled each rising CLK.
REQ-009 OE_n  in  1  active-low output enable for Q.
REQ-010 Q  out  WIDTH  PC value when OE_n=0; high-Z on all bits when OE_n=1.
REQ-011 WRAP  out  1  registered; high for the one cycle after an update that wrapped modulo 2^WIDTH.
REQ-012 FULL  out  1  stack holds DEPTH entries.
REQ-013 EMPTY  out  1  stack holds 0 entries.
REQ-014 LEVEL  out  clog2(DEPTH+1)  current stack occupancy.
REQ-015 ERR  out  1  sticky; set on stack overflow or underflow, cleared only by reset or CLEAR.

Function
REQ-016 The OP encoding SHALL be: 000 HOLD, 001 INC, 010 LOAD, 011 ADD, 100 CALL, 101 RET, 110 CLEAR, 111 reserved (behaves as HOLD).
REQ-017 HOLD: PC, stack, WRAP and ERR SHALL be unchanged, except that WRAP SHALL clear to 0.
REQ-018 INC: PC <= (PC + STEP) mod 2^WIDTH, and WRAP SHALL be 1 if the addition carried out of bit WIDTH-1.
REQ-019 LOAD: PC <= A; WRAP <= 0.
REQ-020 ADD: PC <= (PC + A) mod 2^WIDTH with A treated as signed; WRAP SHALL be 1 on carry-out for a non-negative A and on no-borrow-free result for a negative A (i.e. the result crossed 0/2^WIDTH-1).
REQ-021 CALL when not FULL: push (PC + STEP) mod 2^WIDTH, then PC <= A, LEVEL +1, all in one edge.
REQ-022 CALL when FULL: PC and stack SHALL be unchanged, and ERR <= 1.
REQ-023 RET when not EMPTY: PC <= top entry and LEVEL -1, in one edge.
REQ-024 RET when EMPTY: PC and stack SHALL be unchanged, and ERR <= 1.
REQ-025 CLEAR: PC <= RESET_VALUE, LEVEL <= 0, ERR <= 0, WRAP <= 0.
REQ-026 Latency: the result of an OP sampled at edge N SHALL be visible on Q, LEVEL, FULL, EMPTY, WRAP and ERR after edge N, with no extra cycle.
REQ-027 Q SHALL be combinational from the PC register and OE_n; counting SHALL continue while OE_n=1.
REQ-028 FULL and EMPTY SHALL be decoded from LEVEL and SHALL never both be 1.
REQ-029 Stack entries above LEVEL SHALL be don't-care and never observable.

Reset
REQ-030 RESET_n=0 SHALL immediately force PC=RESET_VALUE, LEVEL=0, EMPTY=1, FULL=0, WRAP=0 and ERR=0, regardless of CLK.
REQ-031 Assertion mid-operation SHALL abandon any in-flight OP; the first edge after release SHALL execute the OP present then.
REQ-032 Stack storage contents need no reset.

Structure
REQ-033 A shared package pc_pkg SHALL hold the OP codes as named constants and the LEVEL width function.
REQ-034 The LIFO SHALL be a sub-module pc_return_stack (params WIDTH, DEPTH; push, pop, data in/out, LEVEL).
REQ-035 The PC register, adder and tri-state driver SHALL reside in pc_stack.

Verification
REQ-036 Reset, OE_n=0, INC x3 -> Q=0x00000003, WRAP=0, EMPTY=1.
REQ-037 LOAD 0xFFFFFFFE, INC, INC -> Q=0xFFFFFFFF then 0x00000000 with WRAP=1 for exactly one cycle.
REQ-038 LOAD 0x100, ADD 0xFFFFFFF0 -> Q=0x000000F0; ADD 0x20 -> Q=0x00000110.
REQ-039 LOAD 0x10, CALL 0x200 x4 (DEPTH=4) -> FULL=1, LEVEL=4; fifth CALL -> Q unchanged 0x200, ERR=1; RET x4 -> Q=0x201,0x201,0x201,0x11, EMPTY=1.
REQ-040 RET on EMPTY -> Q unchanged, ERR=1; CLEAR -> Q=RESET_VALUE, ERR=0.
REQ-041 OE_n=1 -> Q all Z; INC x2; OE_n=0 -> Q advanced by 2; RESET_n pulsed low between edges -> Q=RESET_VALUE before next edge.
